xilinx_distributed_ram_clearable: RTL and testbench
===================================================

// Module: xilinx_distributed_ram_clearable
// PURPOSE
// Bit-write-enabled distributed (LUT) RAM with N async/sync read ports, optional write-first
// forwarding and a hardware clear sequencer that zeroes every entry after reset or on request.
// Used for register files, scoreboards and valid-bit tables that must start from a known state
// without an initial block. One write port; the array itself is never reset, only walked.
// PARAMETERS
// CLOCK_INFO      'b0  std_clock_info_t; clock_edge selects posedge/negedge for all state
// DATA_WIDTH      1    bits per entry
// ADDR_WIDTH      5    DEPTH = 2**ADDR_WIDTH entries
// READ_PORTS      1    independent read ports, >=1
// READ_LATENCY    0    0 = combinational read, 1 = registered read_data_out
// WRITE_FIRST     0    1 = read of address being written returns new bits same cycle
// CLEAR_ON_RESET  1    1 = clear sequence starts automatically when rst deasserts
// PORTS
// clk             in   1                    clock (edge per CLOCK_INFO)
// rst             in   1                    asynchronous, active-low reset
// clear           in   1                    request full clear; sampled only in IDLE
// ready           out  1                    1 = IDLE, writes accepted, read data valid
// write_enable    in   DATA_WIDTH           per-bit write enable
// write_addr      in   ADDR_WIDTH           write address
// write_data_in   in   DATA_WIDTH           write data
// write_data_out  out  DATA_WIDTH           combinational array[write_addr] (pre-write)
// read_addr       in   ADDR_WIDTH x RP      read addresses (unpacked array [READ_PORTS])
// read_data_out   out  DATA_WIDTH x RP      read data (unpacked array [READ_PORTS])
// BEHAVIOUR
// - rst low (async): state <= CLEAR if CLEAR_ON_RESET else IDLE; clear_addr <= 0;
//   ready <= 0 if CLEAR_ON_RESET else 1; registered read_data_out <= 0. Array not reset.
// - FSM IDLE: ready=1; bits k with write_enable[k] written at active edge. clear=1 -> CLEAR
//   next edge, clear_addr=0, user write that same cycle still performed.
// - FSM CLEAR: ready=0; each edge writes all-zero to array[clear_addr], clear_addr++;
//   at clear_addr==DEPTH-1 write last entry, go IDLE (ready=1 next cycle). Exactly DEPTH
//   cycles. clear_addr width ADDR_WIDTH, no wrap beyond DEPTH-1. User write_enable ignored;
//   clear input ignored (no restart).
// - During CLEAR: read_data_out and write_data_out forced to 0 (comb path for latency 0,
//   registered 0 for latency 1).
// - Read, READ_LATENCY=0: read_data_out[i] = array[read_addr[i]] same cycle.
//   READ_LATENCY=1: value registered at edge, visible next cycle.
// - WRITE_FIRST=1, IDLE, read_addr[i]==write_addr: bits with write_enable set take
//   write_data_in, others take array value (latency 0: same cycle; latency 1: the
//   registered value equals post-write contents). WRITE_FIRST=0: old contents for lat 0,
//   new contents for lat 1 (array updated at same edge the output register samples).
// - Multiple read ports may alias the same address; all return identical data.
// - rst mid-CLEAR: restarts from clear_addr=0 (CLEAR_ON_RESET=1) or aborts to IDLE
//   with partially cleared array (CLEAR_ON_RESET=0).
// TESTING
// 1 DW=8,AW=4,CLEAR_ON_RESET=1: release rst -> ready=0 for exactly 16 cycles, then 1;
//   read all 16 addrs -> 0x00.
// 2 write addr 3 data 0xA5 en 0xFF, then en 0x0F data 0x3C -> addr 3 reads 0xAC.
// 3 WRITE_FIRST=1, lat 0: same cycle write 0x5A en 0xF0 to addr 7 (old 0x11), read 7 on
//   both ports -> 0x51 both; WRITE_FIRST=0 -> 0x11 then 0x51 next cycle.
// 4 lat 1: read addr 2 (0x77) -> read_data_out=0x77 exactly one cycle after addr applied;
//   rst low -> output 0 immediately (async).
// 5 fill all with 0xFF, pulse clear with simultaneous write addr 0 -> ready drops next
//   cycle, writes during CLEAR ignored, second clear pulse ignored, all reads 0 after 16.
// 6 assert rst at clear cycle 8 -> on release, full 16-cycle clear repeats; negedge
//   CLOCK_INFO variant passes tests 1-2.

Source files
------------

// File: rtl/xilinx_distributed_ram_clearable.sv
// Bit-write-enabled LUT RAM with N read ports, optional write-first forwarding and a
// hardware clear walker that zeroes every entry after reset or on request.
module xilinx_distributed_ram_clearable #(
  parameter logic [0:0]  CLOCK_INFO     = 1'b0,
  parameter int unsigned DATA_WIDTH     = 1,
  parameter int unsigned ADDR_WIDTH     = 5,
  parameter int unsigned READ_PORTS     = 1,
  parameter int unsigned READ_LATENCY   = 0,
  parameter int unsigned WRITE_FIRST    = 0,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  output logic                  ready,
  input  logic [DATA_WIDTH-1:0] write_enable,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] write_data_in,
  output logic [DATA_WIDTH-1:0] write_data_out,
  input  logic [ADDR_WIDTH-1:0] read_addr [READ_PORTS],
  output logic [DATA_WIDTH-1:0] read_data_out [READ_PORTS]
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  // A registered read always sees post-write contents, so it forwards regardless of WRITE_FIRST.
  localparam bit FWD = (WRITE_FIRST != 0) || (READ_LATENCY != 0);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;

  state_t                  state, state_nx;
  logic [ADDR_WIDTH-1:0]   clear_addr, clear_addr_nx;
  logic                    clearing;
  logic                    clk_e;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [DATA_WIDTH-1:0]   wr_cur;
  logic [DATA_WIDTH-1:0]   wr_merged;

  // Negedge operation is an inverted clock into the same posedge logic.
  assign clk_e = clk ^ CLOCK_INFO[0];

  assign clearing  = (state == S_CLEAR);
  assign ready     = (state == S_IDLE);
  assign wr_cur    = mem[write_addr];
  assign wr_merged = (wr_cur & ~write_enable) | (write_data_in & write_enable);

  assign write_data_out = clearing ? '0 : wr_cur;

  always_ff @(posedge clk_e or negedge rst) begin
    if (!rst) begin
      state      <= RST_STATE;
      clear_addr <= '0;
    end else begin
      state      <= state_nx;
      clear_addr <= clear_addr_nx;
    end
  end

  // Clear walker: one entry per cycle, clear requests ignored while walking.
  always_comb begin
    state_nx      = state;
    clear_addr_nx = clear_addr;
    case (state)
      S_IDLE: begin
        if (clear) begin
          state_nx      = S_CLEAR;
          clear_addr_nx = '0;
        end
      end
      S_CLEAR: begin
        if (clear_addr == LAST_ADDR) begin
          state_nx = S_IDLE;
        end else begin
          clear_addr_nx = clear_addr + ADDR_WIDTH'(1);
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Storage array is never reset; it is only walked by the clear sequencer.
  always_ff @(posedge clk_e) begin
    if (clearing) begin
      mem[clear_addr] <= '0;
    end else begin
      mem[write_addr] <= wr_merged;
    end
  end

  for (genvar i = 0; i < READ_PORTS; i++) begin : g_rd
    logic [DATA_WIDTH-1:0] cur;
    logic [DATA_WIDTH-1:0] nxt;

    assign cur = mem[read_addr[i]];

    always_comb begin
      nxt = cur;
      if (clearing) begin
        nxt = '0;
      end else if (FWD && (read_addr[i] == write_addr)) begin
        nxt = (cur & ~write_enable) | (write_data_in & write_enable);
      end
    end

    if (READ_LATENCY == 0) begin : g_comb
      assign read_data_out[i] = nxt;
    end else begin : g_reg
      always_ff @(posedge clk_e or negedge rst) begin
        if (!rst) begin
          read_data_out[i] <= '0;
        end else begin
          read_data_out[i] <= nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_xilinx_distributed_ram_clearable.sv
// Randomized + directed bench for the clearable distributed RAM; four variants share stimulus
// and are checked against one array-level reference model.
module tb_xilinx_distributed_ram_clearable;

  logic       clk;
  logic       clk_n;
  logic       rst;
  logic       clr;
  logic [7:0] we;
  logic [3:0] wa;
  logic [7:0] wd;
  logic [3:0] ra [2];

  logic       ready0, ready1, ready2, ready3;
  logic [7:0] wdo0, wdo1, wdo2, wdo3;
  logic [7:0] rd0 [2];
  logic [7:0] rd1 [2];
  logic [7:0] rd2 [2];
  logic [7:0] rd3 [2];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: plain array plus a busy countdown for the clear sequence.
  logic [7:0] m_mem [16];
  logic [7:0] m_rd1 [2];
  bit         m_busy;
  int         m_cnt;

  assign clk_n = ~clk;

  // u0: read-first comb, u1: write-first comb, u2: registered, u3: registered on negedge clock
  xilinx_distributed_ram_clearable #(.CLOCK_INFO(1'b0), .DATA_WIDTH(8), .ADDR_WIDTH(4),
    .READ_PORTS(2), .READ_LATENCY(0), .WRITE_FIRST(0), .CLEAR_ON_RESET(1)) u0 (
    .clk(clk), .rst(rst), .clear(clr), .ready(ready0), .write_enable(we), .write_addr(wa),
    .write_data_in(wd), .write_data_out(wdo0), .read_addr(ra), .read_data_out(rd0));

  xilinx_distributed_ram_clearable #(.CLOCK_INFO(1'b0), .DATA_WIDTH(8), .ADDR_WIDTH(4),
    .READ_PORTS(2), .READ_LATENCY(0), .WRITE_FIRST(1), .CLEAR_ON_RESET(1)) u1 (
    .clk(clk), .rst(rst), .clear(clr), .ready(ready1), .write_enable(we), .write_addr(wa),
    .write_data_in(wd), .write_data_out(wdo1), .read_addr(ra), .read_data_out(rd1));

  xilinx_distributed_ram_clearable #(.CLOCK_INFO(1'b0), .DATA_WIDTH(8), .ADDR_WIDTH(4),
    .READ_PORTS(2), .READ_LATENCY(1), .WRITE_FIRST(0), .CLEAR_ON_RESET(1)) u2 (
    .clk(clk), .rst(rst), .clear(clr), .ready(ready2), .write_enable(we), .write_addr(wa),
    .write_data_in(wd), .write_data_out(wdo2), .read_addr(ra), .read_data_out(rd2));

  xilinx_distributed_ram_clearable #(.CLOCK_INFO(1'b1), .DATA_WIDTH(8), .ADDR_WIDTH(4),
    .READ_PORTS(2), .READ_LATENCY(1), .WRITE_FIRST(1), .CLEAR_ON_RESET(1)) u3 (
    .clk(clk_n), .rst(rst), .clear(clr), .ready(ready3), .write_enable(we), .write_addr(wa),
    .write_data_in(wd), .write_data_out(wdo3), .read_addr(ra), .read_data_out(rd3));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Contents of entry a once this cycle's write (if any) has landed.
  function automatic logic [7:0] post(input logic [3:0] a);
    if (!m_busy && a == wa) return (m_mem[a] & ~we) | (wd & we);
    return m_mem[a];
  endfunction

  task automatic model_reset();
    m_busy = 1'b1;
    m_cnt  = 0;
    for (int p = 0; p < 2; p++) m_rd1[p] = 8'h00;
  endtask

  task automatic model_edge();
    if (!rst) return;
    for (int p = 0; p < 2; p++) m_rd1[p] = m_busy ? 8'h00 : post(ra[p]);
    if (m_busy) begin
      m_cnt++;
      if (m_cnt == 16) begin
        m_busy = 1'b0;
        for (int a = 0; a < 16; a++) m_mem[a] = 8'h00;
      end
    end else begin
      m_mem[wa] = post(wa);
      if (clr) begin
        m_busy = 1'b1;
        m_cnt  = 0;
      end
    end
  endtask

  task automatic compare_all();
    logic [7:0] e_wdo;
    logic [7:0] e_old;
    logic [7:0] e_new;
    e_wdo = m_busy ? 8'h00 : m_mem[wa];
    chk("ready_u0", 8'(ready0), 8'(!m_busy));
    chk("ready_u1", 8'(ready1), 8'(!m_busy));
    chk("ready_u2", 8'(ready2), 8'(!m_busy));
    chk("ready_u3", 8'(ready3), 8'(!m_busy));
    chk("wdo_u0", wdo0, e_wdo);
    chk("wdo_u1", wdo1, e_wdo);
    chk("wdo_u2", wdo2, e_wdo);
    chk("wdo_u3", wdo3, e_wdo);
    for (int p = 0; p < 2; p++) begin
      e_old = m_busy ? 8'h00 : m_mem[ra[p]];
      e_new = m_busy ? 8'h00 : post(ra[p]);
      chk($sformatf("rd_u0_p%0d", p), rd0[p], e_old);
      chk($sformatf("rd_u1_p%0d", p), rd1[p], e_new);
      chk($sformatf("rd_u2_p%0d", p), rd2[p], m_rd1[p]);
      chk($sformatf("rd_u3_p%0d", p), rd3[p], m_rd1[p]);
    end
  endtask

  // Called at posedge+1; samples at posedge+8.
  task automatic sample();
    #7;
    compare_all();
  endtask

  task automatic advance();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    #1;
    chk("async_rst_u2", rd2[0], 8'h00);
    chk("async_rst_u3", rd3[0], 8'h00);
    chk("async_rst_ready", 8'(ready0), 8'h00);
    repeat (2) begin
      sample();
      advance();
    end
    rst = 1'b1;
  endtask

  task automatic wait_clear(output int n);
    n = 0;
    while (n < 40) begin
      sample();
      if (ready0) break;
      n++;
      advance();
    end
    advance();
  endtask

  int n_low;

  initial begin
    rst = 1'b1; clr = 1'b0; we = 8'h00; wa = 4'd0; wd = 8'h00;
    ra[0] = 4'd0; ra[1] = 4'd0;
    for (int a = 0; a < 16; a++) m_mem[a] = 8'h00;
    model_reset();
    @(posedge clk);
    #1;

    // Reset-triggered clear lasts exactly 16 cycles, then everything reads zero.
    do_reset();
    wait_clear(n_low);
    chk("clear_len_reset", 8'(n_low), 8'd16);
    for (int a = 0; a < 16; a++) begin
      ra[0] = 4'(a); ra[1] = 4'(15 - a);
      sample();
      chk("zero_after_reset", rd0[0], 8'h00);
      advance();
    end

    // Bit-enabled writes merge into existing contents.
    wa = 4'd3; wd = 8'hA5; we = 8'hFF; sample(); advance();
    wd = 8'h3C; we = 8'h0F; sample(); advance();
    we = 8'h00; ra[0] = 4'd3; ra[1] = 4'd3;
    sample(); chk("bitwe_u0", rd0[0], 8'hAC); advance();
    sample(); chk("bitwe_u2", rd2[0], 8'hAC); advance();

    // Same-cycle write/read on both ports: forwarding vs old contents.
    wa = 4'd7; wd = 8'h11; we = 8'hFF; sample(); advance();
    wd = 8'h5A; we = 8'hF0; ra[0] = 4'd7; ra[1] = 4'd7;
    sample();
    chk("wf_u1_p0", rd1[0], 8'h51);
    chk("wf_u1_p1", rd1[1], 8'h51);
    chk("rf_u0_old", rd0[0], 8'h11);
    advance();
    we = 8'h00;
    sample();
    chk("rf_u0_new", rd0[0], 8'h51);
    chk("lat1_post_write", rd2[0], 8'h51);
    advance();

    // Registered read appears one cycle after its address, async reset zeroes it.
    wa = 4'd2; wd = 8'h77; we = 8'hFF; sample(); advance();
    we = 8'h00; ra[0] = 4'd2; ra[1] = 4'd2;
    sample(); chk("lat1_prev_addr", rd2[0], 8'h51); advance();
    sample(); chk("lat1_u2", rd2[0], 8'h77); chk("lat1_u3", rd3[0], 8'h77); advance();
    do_reset();

    // Reset in the middle of the clear walk restarts a full walk.
    repeat (8) begin
      sample();
      advance();
    end
    do_reset();
    wait_clear(n_low);
    chk("clear_len_restart", 8'(n_low), 8'd16);

    // Fill, request clear alongside a write, and hammer writes/clears during the walk.
    for (int a = 0; a < 16; a++) begin
      wa = 4'(a); wd = 8'hFF; we = 8'hFF;
      sample(); advance();
    end
    wa = 4'd0; wd = 8'h00; we = 8'hFF; clr = 1'b1;
    sample(); chk("ready_before_clear", 8'(ready0), 8'h01); advance();
    clr = 1'b0; wd = 8'hAA; wa = 4'd5;
    sample(); chk("ready_drop", 8'(ready0), 8'h00); advance();
    n_low = 1;
    while (n_low < 40) begin
      wa = 4'($urandom_range(0, 15));
      clr = (n_low == 4);
      sample();
      if (ready0) break;
      n_low++;
      advance();
    end
    we = 8'h00; clr = 1'b0;
    advance();
    chk("clear_len_request", 8'(n_low), 8'd16);
    for (int a = 0; a < 16; a++) begin
      ra[0] = 4'(a); ra[1] = 4'(a);
      sample();
      chk("zero_after_clear", rd1[1], 8'h00);
      advance();
    end

    // Random traffic with aliasing ports and occasional clears.
    for (int c = 0; c < 600; c++) begin
      case ($urandom_range(0, 3))
        0: we = 8'h00;
        1: we = 8'hFF;
        default: we = 8'($urandom_range(0, 255));
      endcase
      wa = 4'($urandom_range(0, 15));
      wd = 8'($urandom_range(0, 255));
      ra[0] = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, 15));
      ra[1] = ($urandom_range(0, 3) == 0) ? ra[0] : 4'($urandom_range(0, 15));
      clr = ($urandom_range(0, 49) == 0);
      sample();
      advance();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
